// File: rtl/gpu_pkg.sv
// Shared types for the pixel write path.
//   pixel_t    : one buffered pixel {target frame, pixel index, RGB565 color}
//   wr_state_t : SRAM write-cycle FSM states
//   FB_W/FB_H  : frame-buffer geometry (640x480)
package gpu_pkg;

  localparam int FB_W = 640;
  localparam int FB_H = 480;

  typedef struct packed {
    logic        frame;
    logic [18:0] addr;
    logic [15:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO of pixel_t entries.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write an entry (caller only pushes when !full or popping)
//   pop/head : head is the oldest entry, read combinationally; pop drops it
//   full     : DEPTH entries stored
//   empty    : no entries stored
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the wrap bit while the index bits match.
module pix_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output pixel_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  pixel_t      mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // A push at full only happens alongside a pop; the head has already been
  // consumed by the reader when the slot is overwritten at the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/pixel_write_ctrl.sv
// Pixel stream consumer: buffers pixels from the core and writes them to the
// frame-buffer SRAM with a SETUP / STROBE / HOLD cycle; owns the front/back
// frame selection.
//   clk, rst        : clock, synchronous active-high reset
//   data_ready      : core presents {address, color, frame_target}
//   data_sent       : 1-cycle pulse, pixel accepted
//   swap_req/ack    : level swap request / 1-cycle acknowledge
//   display_frame   : frame currently scanned out
//   sram_*          : registered SRAM pins (ce/we active-high)
//   oob_err         : sticky, a pixel with address >= PIX_LIMIT was dropped
//   state_dbg       : current write-FSM state
// Handshake: the core raises data_ready and holds its inputs; the cycle after
// the pixel is taken data_sent pulses for one cycle and the core may present
// the next pixel. data_sent is never high two cycles running, so a held
// data_ready is never taken twice.
// The SRAM pins are registered from the FSM state, so the pin phases trail
// the state by one cycle (accept -> we rising is 3 cycles from idle).
module pixel_write_ctrl
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STROBE_CYC = 2,
  parameter int PIX_LIMIT  = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ready,
  input  logic [18:0] address,
  input  logic [15:0] color,
  input  logic        frame_target,
  output logic        data_sent,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        display_frame,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_ce,
  output logic        sram_we,
  output logic        oob_err,
  output wr_state_t   state_dbg
);

  localparam logic [18:0] LIMIT = 19'(PIX_LIMIT);
  localparam int          CW    = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYC - 1);

  wr_state_t     state;
  wr_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          hs;
  logic          oob;
  logic          take_swap;
  logic          swap_done;
  pixel_t        head;
  pixel_t        din;

  assign oob  = (address >= LIMIT);
  assign pop  = (state == SETUP);
  // Out-of-range pixels complete the handshake without needing FIFO space;
  // at full a pop in the same cycle frees the slot for the push.
  assign hs   = data_ready && !data_sent && (oob || !full || pop);
  assign push = hs && !oob;
  assign din  = {frame_target, address, color};

  assign take_swap = swap_req && !swap_done && (state == IDLE) && empty && !hs;

  pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt == CNT_LAST) state_nx = HOLD;
      HOLD:    state_nx = empty ? IDLE : SETUP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      data_sent     <= 1'b0;
      swap_ack      <= 1'b0;
      swap_done     <= 1'b0;
      display_frame <= 1'b0;
      oob_err       <= 1'b0;
      sram_ce       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= (state == STROBE && cnt != CNT_LAST) ? cnt + 1'b1 : '0;
      data_sent <= hs;
      swap_ack  <= take_swap;
      if (take_swap) display_frame <= ~display_frame;
      // Re-armed only once the request level drops.
      if (!swap_req)      swap_done <= 1'b0;
      else if (take_swap) swap_done <= 1'b1;
      if (hs && oob) oob_err <= 1'b1;
      sram_ce <= (state != IDLE);
      sram_we <= (state == STROBE);
      if (state == SETUP) begin
        sram_addr  <= {head.frame, head.addr};
        sram_wdata <= head.color;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// Self-checking bench for pixel_write_ctrl: directed vector table for single
// pixels, then burst, swap and reset-during-write sequences.
module tb_pixel_write_ctrl;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready = 1'b0;
  logic [18:0] address = '0;
  logic [15:0] color = '0;
  logic        frame_target = 1'b0;
  logic        swap_req = 1'b0;
  logic        data_sent, swap_ack, display_frame, sram_ce, sram_we, oob_err;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  wr_state_t   state_dbg;

  pixel_write_ctrl dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .address(address),
    .color(color), .frame_target(frame_target), .data_sent(data_sent),
    .swap_req(swap_req), .swap_ack(swap_ack), .display_frame(display_frame),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ce(sram_ce),
    .sram_we(sram_we), .oob_err(oob_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / SRAM monitor ----------------
  logic [35:0] exp_q[$];
  int          rise_q[$];
  bit          sb_on = 1'b1;
  logic        we_q = 1'b0, ce_q = 1'b0;
  int wr_cnt = 0, we_len = 0, last_len = 0, last_rise = 0;
  int last_we_fall = 0, last_ce_fall = 0;
  int ack_cnt = 0, ack_cyc = 0, ack_wr = 0;

  always @(negedge clk) begin
    if (sram_we && !we_q) begin
      wr_cnt++;
      last_rise = cyc;
      rise_q.push_back(cyc);
      we_len = 0;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h expected=none", {sram_addr, sram_wdata});
        end else begin
          chk("sram_write", {sram_addr, sram_wdata}, exp_q.pop_front());
        end
      end
    end
    if (sram_we) we_len++;
    if (!sram_we && we_q) begin
      last_len     = we_len;
      last_we_fall = cyc;
    end
    if (!sram_ce && ce_q) last_ce_fall = cyc;
    if (swap_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      ack_wr  = wr_cnt;
    end
    we_q = sram_we;
    ce_q = sram_ce;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns aligned at posedge+1 with data_ready low.
  task automatic send(input logic [18:0] a, input logic [15:0] c, input logic ft, output int acc);
    bit got = 1'b0;
    address = a; color = c; frame_target = ft; data_ready = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (data_sent) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL data_sent_timeout actual=0 expected=1 addr=%0h", a);
    end
    step();
    data_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (state_dbg == IDLE && !sram_ce && !data_sent) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout actual=busy expected=idle", name);
    end
    repeat (2) @(negedge clk);
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [18:0] addr;
    logic [15:0] color;
    logic        ft;
    logic        exp_wr;
    logic [19:0] exp_sa;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[7];
  int   acc, w0, w1, a0, maxg;
  int   acc_a[20];
  logic [18:0] ba;
  logic [15:0] bc;
  logic        bf;
  bit          done;

  initial begin
    vecs[0] = '{19'h00123, 16'hF800, 1'b1, 1'b1, 20'h80123, 1'b0};
    vecs[1] = '{19'h00000, 16'h07E0, 1'b0, 1'b1, 20'h00000, 1'b0};
    vecs[2] = '{19'h4AFFF, 16'h001F, 1'b1, 1'b1, 20'hCAFFF, 1'b0};
    vecs[3] = '{19'h3FFFF, 16'hFFFF, 1'b0, 1'b1, 20'h3FFFF, 1'b0};
    vecs[4] = '{19'h4B000, 16'h1234, 1'b0, 1'b0, 20'h00000, 1'b1};
    vecs[5] = '{19'h00ABC, 16'hA5A5, 1'b1, 1'b1, 20'h80ABC, 1'b1};
    vecs[6] = '{19'h7FFFF, 16'h5555, 1'b0, 1'b0, 20'h00000, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_sent", data_sent, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_display", display_frame, 0);
    chk("rst_ce", sram_ce, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_state", state_dbg, IDLE);
    step();
    rst = 1'b0;
    step();

    // single-pixel vectors
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_wr) exp_q.push_back({vecs[i].exp_sa, vecs[i].color});
      w0 = wr_cnt;
      send(vecs[i].addr, vecs[i].color, vecs[i].ft, acc);
      wait_idle("vec");
      chk($sformatf("vec%0d_writes", i), wr_cnt - w0, vecs[i].exp_wr);
      if (vecs[i].exp_wr) begin
        chk($sformatf("vec%0d_latency", i), last_rise - acc, 3);
        chk($sformatf("vec%0d_we_len", i), last_len, 2);
        chk($sformatf("vec%0d_ce_tail", i), last_ce_fall - last_we_fall, 1);
      end
      chk($sformatf("vec%0d_oob", i), oob_err, vecs[i].exp_oob);
    end

    // reset clears sticky oob_err
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("oob_cleared", oob_err, 0);
    step();

    // burst of 20 back-to-back pixels: fills the FIFO, drains in order
    w0 = wr_cnt;
    rise_q.delete();
    for (int i = 0; i < 20; i++) begin
      ba = 19'(i * 7 + 100);
      bc = 16'($urandom_range(0, 65535));
      bf = i[0];
      exp_q.push_back({bf, ba, bc});
      send(ba, bc, bf, acc_a[i]);
    end
    wait_idle("burst");
    chk("burst_writes", wr_cnt - w0, 20);
    for (int i = 1; i < 20; i++) chk($sformatf("burst_spacing%0d", i), rise_q[i] - rise_q[i-1], 4);
    maxg = 0;
    for (int i = 1; i < 20; i++) if (acc_a[i] - acc_a[i-1] > maxg) maxg = acc_a[i] - acc_a[i-1];
    chk("burst_first_gap", acc_a[1] - acc_a[0], 2);
    chk("burst_full_stall", maxg > 2, 1);

    // swap with 3 pixels queued
    w0 = wr_cnt;
    a0 = ack_cnt;
    swap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 19'(i + 500), 16'(i + 16'h0100)});
      send(19'(i + 500), 16'(i + 16'h0100), 1'b0, acc);
    end
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ack_cnt != a0) done = 1'b1;
    end
    @(negedge clk);
    chk("swap_ack_count", ack_cnt - a0, 1);
    chk("swap_after_writes", ack_wr - w0, 3);
    chk("swap_after_hold", ack_cyc - last_we_fall, 1);
    chk("swap_display", display_frame, 1);
    repeat (10) @(negedge clk);
    chk("swap_edge_qualified", ack_cnt - a0, 1);
    step();
    swap_req = 1'b0;
    step();

    // reset during STROBE aborts the write and empties the FIFO
    sb_on = 1'b0;
    for (int i = 0; i < 3; i++) send(19'(i + 900), 16'hBEEF, 1'b1, acc);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sram_we) done = 1'b1;
    end
    chk("strobe_reached", done, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_we", sram_we, 0);
    chk("abort_ce", sram_ce, 0);
    chk("abort_display", display_frame, 0);
    chk("abort_state", state_dbg, IDLE);
    step();
    rst = 1'b0;
    w1 = wr_cnt;
    repeat (30) @(negedge clk);
    chk("abort_fifo_empty", wr_cnt - w1, 0);
    step();
    sb_on = 1'b1;

    // fresh swap after reset
    a0 = ack_cnt;
    swap_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ack_cnt != a0) done = 1'b1;
    end
    @(negedge clk);
    chk("swap2_ack", ack_cnt - a0, 1);
    chk("swap2_display", display_frame, 1);
    step();
    swap_req = 1'b0;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
